// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared CSR addresses, misa default and mtvec mode encoding
package csr_pkg;

    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;

    // MXL=1 (RV32), I extension only
    localparam logic [31:0] MISA_DEFAULT = 32'h4000_0100;

    typedef enum logic [1:0] {
        DIRECT   = 2'b00,
        VECTORED = 2'b01
    } mtvec_mode_e;

    // mtvec accepts only the two defined modes; anything else keeps the old value
    function automatic logic mtvec_mode_legal(input logic [1:0] mode);
        return (mode == DIRECT) || (mode == VECTORED);
    endfunction

endpackage

// File: rtl/machine_csr_file.sv
// rtl/machine_csr_file.sv - machine-mode CSR file with main port and trap side ports
module machine_csr_file
    import csr_pkg::*;
#(
    parameter int               XLEN       = 32,
    parameter logic [XLEN-1:0]  MISA_VALUE = MISA_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [11:0]     a,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] dout,
    input  logic            mepc_we,
    input  logic [XLEN-1:0] mepc_din,
    input  logic            mcause_we,
    input  logic [XLEN-1:0] mcause_din,
    output logic [XLEN-1:0] mepc_dout,
    output logic [XLEN-1:0] mtvec_dout,
    output logic [XLEN-1:0] mcause_dout
);

    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;

    logic main_mtvec;
    logic main_mscratch;
    logic main_mepc;

    assign main_mtvec    = we && (a == CSR_MTVEC);
    assign main_mscratch = we && (a == CSR_MSCRATCH);
    assign main_mepc     = we && (a == CSR_MEPC);

    // mtvec: WARL, illegal mode encodings are dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtvec_q <= '0;
        end else if (main_mtvec && mtvec_mode_legal(din[1:0])) begin
            mtvec_q <= din;
        end
    end

    // mscratch: plain read/write scratch register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mscratch_q <= '0;
        end else if (main_mscratch) begin
            mscratch_q <= din;
        end
    end

    // mepc: word aligned; trap-logic write takes priority over the main port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mepc_q <= '0;
        end else if (mepc_we) begin
            mepc_q <= {mepc_din[XLEN-1:2], 2'b00};
        end else if (main_mepc) begin
            mepc_q <= {din[XLEN-1:2], 2'b00};
        end
    end

    // mcause: written only by the trap logic
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcause_q <= '0;
        end else if (mcause_we) begin
            mcause_q <= mcause_din;
        end
    end

    // main read port decode, zero latency
    always_comb begin
        dout = '0;
        case (a)
            CSR_MISA:     dout = MISA_VALUE;
            CSR_MTVEC:    dout = mtvec_q;
            CSR_MSCRATCH: dout = mscratch_q;
            CSR_MEPC:     dout = mepc_q;
            CSR_MCAUSE:   dout = mcause_q;
            default:      dout = '0;
        endcase
    end

    assign mepc_dout   = mepc_q;
    assign mtvec_dout  = mtvec_q;
    assign mcause_dout = mcause_q;

endmodule

// File: tb/tb_machine_csr_file.sv
// tb/tb_machine_csr_file.sv - directed table-driven bench for machine_csr_file
module tb_machine_csr_file;

    logic        clk;
    logic        reset;
    logic        we;
    logic [11:0] a;
    logic [31:0] din;
    logic [31:0] dout;
    logic        mepc_we;
    logic [31:0] mepc_din;
    logic        mcause_we;
    logic [31:0] mcause_din;
    logic [31:0] mepc_dout;
    logic [31:0] mtvec_dout;
    logic [31:0] mcause_dout;

    int checks = 0;
    int errors = 0;

    machine_csr_file dut (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .a           (a),
        .din         (din),
        .dout        (dout),
        .mepc_we     (mepc_we),
        .mepc_din    (mepc_din),
        .mcause_we   (mcause_we),
        .mcause_din  (mcause_din),
        .mepc_dout   (mepc_dout),
        .mtvec_dout  (mtvec_dout),
        .mcause_dout (mcause_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [11:0] a;
        logic [31:0] din;
        logic        mepc_we;
        logic [31:0] mepc_din;
        logic        mcause_we;
        logic [31:0] mcause_din;
        logic [11:0] read_a;
        logic [31:0] exp_dout;
        logic [31:0] exp_mtvec;
        logic [31:0] exp_mepc;
        logic [31:0] exp_mcause;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        we         = 1'b0;
        mepc_we    = 1'b0;
        mcause_we  = 1'b0;
        din        = '0;
        mepc_din   = '0;
        mcause_din = '0;
    endtask

    task automatic add(input string name, input logic w, input logic [11:0] ad, input logic [31:0] d,
                       input logic pw, input logic [31:0] pd, input logic cw, input logic [31:0] cd,
                       input logic [11:0] ra, input logic [31:0] ed, input logic [31:0] et,
                       input logic [31:0] ep, input logic [31:0] ec);
        vec_t v;
        v.name = name; v.we = w; v.a = ad; v.din = d;
        v.mepc_we = pw; v.mepc_din = pd; v.mcause_we = cw; v.mcause_din = cd;
        v.read_a = ra; v.exp_dout = ed; v.exp_mtvec = et; v.exp_mepc = ep; v.exp_mcause = ec;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1;
        a     = '0;
        idle_inputs();

        // async reset with no clock edge involved
        #1 reset = 1'b0;
        #1;
        check("reset_mtvec", mtvec_dout, 32'h0);
        check("reset_mepc", mepc_dout, 32'h0);
        check("reset_mcause", mcause_dout, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        a = 12'h301; #1 check("reset_misa", dout, 32'h4000_0100);
        a = 12'h305; #1 check("reset_mtvec_rd", dout, 32'h0);
        a = 12'h341; #1 check("reset_mepc_rd", dout, 32'h0);

        //   name             we  a       din          pw  pdin         cw  cdin         rd_a    dout          mtvec   mepc         mcause
        add("misa_ro",        1, 12'h301, 32'd420,      0, 0,           0, 0,           12'h301, 32'h40000100, 32'h0,  32'h0,       32'h0);
        add("mtvec_fc",       1, 12'h305, 32'hFC,       0, 0,           0, 0,           12'h305, 32'hFC,       32'hFC, 32'h0,       32'h0);
        add("mtvec_ff",       1, 12'h305, 32'hFF,       0, 0,           0, 0,           12'h305, 32'hFC,       32'hFC, 32'h0,       32'h0);
        add("mtvec_fe",       1, 12'h305, 32'hFE,       0, 0,           0, 0,           12'h305, 32'hFC,       32'hFC, 32'h0,       32'h0);
        add("mtvec_fd",       1, 12'h305, 32'hFD,       0, 0,           0, 0,           12'h305, 32'hFD,       32'hFD, 32'h0,       32'h0);
        add("mtvec_we0",      0, 12'h305, 32'h1234,     0, 0,           0, 0,           12'h305, 32'hFD,       32'hFD, 32'h0,       32'h0);
        add("mscratch_wr",    1, 12'h340, 32'd45446848, 0, 0,           0, 0,           12'h340, 32'd45446848, 32'hFD, 32'h0,       32'h0);
        add("mepc_main",      1, 12'h341, 32'd86492168, 0, 0,           0, 0,           12'h341, 32'd86492168, 32'hFD, 32'd86492168, 32'h0);
        add("mepc_align",     1, 12'h341, 32'h103,      0, 0,           0, 0,           12'h341, 32'h100,      32'hFD, 32'h100,     32'h0);
        add("mcause_main_ro", 1, 12'h342, 32'd508943,   0, 0,           0, 0,           12'h342, 32'h0,        32'hFD, 32'h100,     32'h0);
        add("mepc_trap",      0, 12'h000, 32'h0,        1, 32'd80,      0, 0,           12'h341, 32'd80,       32'hFD, 32'd80,      32'h0);
        add("mepc_trap_hold", 0, 12'h000, 32'h0,        0, 32'd0,       0, 0,           12'h341, 32'd80,       32'hFD, 32'd80,      32'h0);
        add("mepc_trap_algn", 0, 12'h000, 32'h0,        1, 32'h87,      0, 0,           12'h341, 32'h84,       32'hFD, 32'h84,      32'h0);
        add("mcause_trap",    0, 12'h000, 32'h0,        0, 0,           1, 32'd986,     12'h342, 32'd986,      32'hFD, 32'h84,      32'd986);
        add("mcause_hold",    0, 12'h000, 32'h0,        0, 0,           0, 32'd20,      12'h342, 32'd986,      32'hFD, 32'h84,      32'd986);
        add("mcause_full",    0, 12'h000, 32'h0,        0, 0,           1, 32'h8000000B, 12'h342, 32'h8000000B, 32'hFD, 32'h84,     32'h8000000B);
        add("mepc_collide",   1, 12'h341, 32'd4,        1, 32'd8,       0, 0,           12'h341, 32'd8,        32'hFD, 32'd8,       32'h8000000B);
        add("unmapped_wr",    1, 12'h7C0, 32'hDEADBEEF, 0, 0,           0, 0,           12'h7C0, 32'h0,        32'hFD, 32'd8,       32'h8000000B);

        foreach (vecs[i]) begin
            @(negedge clk);
            we = vecs[i].we; a = vecs[i].a; din = vecs[i].din;
            mepc_we = vecs[i].mepc_we; mepc_din = vecs[i].mepc_din;
            mcause_we = vecs[i].mcause_we; mcause_din = vecs[i].mcause_din;
            @(posedge clk);
            #1;
            idle_inputs();
            a = vecs[i].read_a;
            #1;
            check({vecs[i].name, "_dout"}, dout, vecs[i].exp_dout);
            check({vecs[i].name, "_mtvec"}, mtvec_dout, vecs[i].exp_mtvec);
            check({vecs[i].name, "_mepc"}, mepc_dout, vecs[i].exp_mepc);
            check({vecs[i].name, "_mcause"}, mcause_dout, vecs[i].exp_mcause);
        end

        // mscratch untouched by the unmapped write
        a = 12'h340; #1 check("mscratch_kept", dout, 32'd45446848);

        // reset asserted between edges clears everything immediately
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midreset_mtvec", mtvec_dout, 32'h0);
        check("midreset_mepc", mepc_dout, 32'h0);
        check("midreset_mcause", mcause_dout, 32'h0);
        a = 12'h340; #1 check("midreset_mscratch", dout, 32'h0);

        // reset dominates writes across an edge
        we = 1'b1; a = 12'h340; din = 32'h5555_AAAA;
        mepc_we = 1'b1; mepc_din = 32'h1000;
        mcause_we = 1'b1; mcause_din = 32'h7;
        @(posedge clk);
        #1;
        check("resetdom_mscratch", dout, 32'h0);
        check("resetdom_mepc", mepc_dout, 32'h0);
        check("resetdom_mcause", mcause_dout, 32'h0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        a = 12'h301; #1 check("post_reset_misa", dout, 32'h4000_0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
